img2col_stream: RTL and testbench
=================================

Name: img2col_stream

Overview:
- Streaming image-to-column converter between the feature-map DMA input stream and the matrix-multiply array.
- Accepts a feature map one 64-bit word at a time (8 int8 channels per word, raster order, channels innermost) and buffers Kernel_Size input rows in an on-chip circular line buffer.
- For each output pixel, emits its K×K×C patch as 64-bit words, repeating each patch once per output-channel group.
- Geometry is run-time configurable through input ports sampled at start.

Parameters:
DATA_W, 64, stream word width (8 channels × 8 bit)
CFG_W, 16, width of every configuration port
MAX_K, 16, maximum Kernel_Size (line-buffer row count)
MAX_INCOL, 896, maximum InCol_Count_Times (words per input row)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset (bench signal rst; clock clk)
start  in  1  one-cycle pulse: latch config, begin frame
sData_valid  in  1  input word valid
sData_ready  out  1  input word accepted when valid&ready
sData_payload  in  64  input word
Stride, Kernel_Size, Window_Size, InFeature_Size, InFeature_Channel, OutFeature_Channel, OutFeature_Size, OutCol_Count_Times, InCol_Count_Times, OutRow_Count_Times, OutFeature_Channel_Count_Times, Sliding_Size  in  CFG_W each  geometry (see Behaviour)
mData  out  64  output word
mValid  out  1  output valid
mLast  out  1  last word of frame, qualified by mValid
mReady  in  1  downstream ready
Fifo_Clear  in  1  sampled with start: 1 flushes output FIFO
Test_Signal  out  1  high with mValid while emitting selected output row
Test_End  out  1  one-cycle pulse after last word of selected row
Test_Generate_Period  in  CFG_W  selected output row, 1-based

Behaviour:
Reset and outputs:
- On reset, all outputs are 0, the FSM is IDLE and the output FIFO is empty.
- Reset mid-frame aborts the frame immediately.

Configuration meaning:
- InCol_Count_Times = InFeature_Size×InFeature_Channel/8 (words per row).
- Window_Size = Kernel_Size×InFeature_Channel/8 (words per kernel row).
- Sliding_Size = Stride×InFeature_Channel/8 (word offset between adjacent output columns).
- OutFeature_Channel_Count_Times = OutFeature_Channel/8 (patch repeats).
- OutCol_Count_Times = number of equal column groups; OutFeature_Size must be divisible by it.
- Stride ≤ Kernel_Size.
- Config is latched on start; start is ignored unless IDLE.

FSM: IDLE → LOAD → EMIT → (LOAD | DRAIN | IDLE).
- LOAD: sData_ready=1. Accepts Kernel_Size rows before output row 0, and Stride rows before each later output row. Rows are written at line-buffer slot (row index mod Kernel_Size).
- EMIT: sData_ready=0. Loop order, outermost first:
  - column group cg < OutCol_Count_Times
  - channel group g < OutFeature_Channel_Count_Times
  - column c in group
  - kernel row kr < Kernel_Size
  - word w < Window_Size
- The word emitted is line-buffer row (top+kr) mod K, word c_abs×Sliding_Size + w.
- DRAIN: accept and discard the remaining InFeature_Size − ((OutRow_Count_Times−1)×Stride + Kernel_Size) rows, then go IDLE. Skip DRAIN if the count is 0.

Output path and handshake:
- Line-buffer read latency is 1 cycle, feeding a 4-entry output FIFO.
- Reads stall when the FIFO is almost full, so no word is lost or duplicated.
- mData/mValid/mLast are held stable while mValid&!mReady.
- mLast is set on the final word of the final output row.
- Fifo_Clear=1 at start empties the FIFO before the frame.

Debug outputs:
- Test_Signal = mValid & (current output row+1 == Test_Generate_Period).
- Test_End pulses the cycle after that row's last word handshakes.

Other rules:
- Input words arriving while not in LOAD/DRAIN are not accepted (ready=0).
- Frame output word count = OutRow×OutChGroups×OutFeature_Size×Kernel_Size×Window_Size.

Test Plan:
- Basic frame:
  - Stimulus: K=2, S=2, InFeature_Size=4, Ch=8, InCol=4, Window=2, Sliding=2, OutFeature_Size=2, OutRow=2, OutCol=1, OutChGroups=1; words 0..15 in order, mReady=1.
  - Required output: 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15; mLast only on 15.
- Overlapped windows:
  - Stimulus: K=2, S=1, size 3 (InCol=3, Window=2, Sliding=1, OutFeature_Size=2, OutRow=2); words 0..8.
  - Required output: 0,1,3,4,1,2,4,5,3,4,6,7,4,5,7,8.
- Channel-group repeat:
  - Stimulus: first config with OutChGroups=2.
  - Required output: row 0 = 0,1,4,5,2,3,6,7 emitted twice, then row 1 twice; 32 words total.
- Backpressure:
  - Stimulus: toggle mReady 1-of-3 cycles and sData_valid randomly.
  - Required response: output sequence identical to the basic-frame case; no drops or duplicates; mData stable while stalled.
- Debug capture:
  - Stimulus: Test_Generate_Period=2 on the basic-frame case.
  - Required response: Test_Signal high only on words 8..15; Test_End pulses once after word 15.
- Reset mid-frame:
  - Stimulus: assert reset during EMIT, then restart.
  - Required response: all outputs 0 next cycle; the following start produces a full correct frame.

Source files
------------

// File: rtl/img2col_stream.sv
// Streaming image-to-column converter: buffers Kernel_Size input rows in a circular
// line buffer and replays each output pixel's KxKxC patch through a small output FIFO.
module img2col_stream #(
    parameter int DATA_W    = 64,
    parameter int CFG_W     = 16,
    parameter int MAX_K     = 16,
    parameter int MAX_INCOL = 896
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sData_valid,
    output logic              sData_ready,
    input  logic [DATA_W-1:0] sData_payload,
    input  logic [CFG_W-1:0]  Stride,
    input  logic [CFG_W-1:0]  Kernel_Size,
    input  logic [CFG_W-1:0]  Window_Size,
    input  logic [CFG_W-1:0]  InFeature_Size,
    input  logic [CFG_W-1:0]  InFeature_Channel,
    input  logic [CFG_W-1:0]  OutFeature_Channel,
    input  logic [CFG_W-1:0]  OutFeature_Size,
    input  logic [CFG_W-1:0]  OutCol_Count_Times,
    input  logic [CFG_W-1:0]  InCol_Count_Times,
    input  logic [CFG_W-1:0]  OutRow_Count_Times,
    input  logic [CFG_W-1:0]  OutFeature_Channel_Count_Times,
    input  logic [CFG_W-1:0]  Sliding_Size,
    output logic [DATA_W-1:0] mData,
    output logic              mValid,
    output logic              mLast,
    input  logic              mReady,
    input  logic              Fifo_Clear,
    output logic              Test_Signal,
    output logic              Test_End,
    input  logic [CFG_W-1:0]  Test_Generate_Period
);

    localparam int LB_DEPTH = MAX_K * MAX_INCOL;
    localparam int ADDR_W   = $clog2(LB_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DRAIN} state_t;

    state_t state_q, state_d;

    // Latched geometry
    logic [CFG_W-1:0] k_q, s_q, win_q, ifs_q, ofs_q, oc_q, incol_q, orow_q, ocg_q, sl_q, tgp_q;

    // Input-side counters
    logic [CFG_W-1:0] wslot_q, wcol_q, row_in_q, rows_left_q;

    // Emit-side counters
    logic [CFG_W-1:0]   top_q, out_row_q, w_q, kr_q, kslot_q, g_q, cg_q, base_q, gbase_q;
    logic [2*CFG_W-1:0] acc_q;

    // Read pipeline and output FIFO
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_v_q, rd_last_q, rd_rowend_q, rd_sel_q;
    logic [DATA_W-1:0] fifo_data_q [4];
    logic [2:0]        fifo_tag_q  [4];
    logic [1:0]        fifo_wp_q, fifo_rp_q;
    logic [2:0]        fifo_cnt_q;
    logic              te_q;

    logic [DATA_W-1:0] lb_mem [LB_DEPTH];

    logic               start_go, accept, in_row_end, fifo_room, rd_en, wr_en;
    logic               w_end, kr_end, col_end, g_end, cg_end, row_end_rd, emit_done, last_row;
    logic [CFG_W-1:0]   drain_rows, top_next;
    logic [CFG_W:0]     top_sum;
    logic [ADDR_W-1:0]  lb_waddr, lb_raddr;
    logic               push, pop;

    // Channel counts are already folded into the word-based geometry ports.
    logic unused_cfg;
    assign unused_cfg = ^{InFeature_Channel, OutFeature_Channel};

    assign start_go   = start && (state_q == S_IDLE);
    assign accept     = sData_valid && sData_ready;
    assign in_row_end = (wcol_q == incol_q - CFG_W'(1));
    assign fifo_room  = (4'(fifo_cnt_q) + 4'(rd_v_q)) < 4'd4;
    assign rd_en      = (state_q == S_EMIT) && fifo_room;
    assign wr_en      = accept && (state_q == S_LOAD);

    assign w_end      = (w_q == win_q - CFG_W'(1));
    assign kr_end     = (kr_q == k_q - CFG_W'(1));
    assign col_end    = (acc_q == {{CFG_W{1'b0}}, ofs_q});
    assign g_end      = (g_q == ocg_q - CFG_W'(1));
    assign cg_end     = (cg_q == oc_q - CFG_W'(1));
    assign row_end_rd = w_end && kr_end && col_end && g_end && cg_end;
    assign emit_done  = rd_en && row_end_rd;
    assign last_row   = (out_row_q == orow_q - CFG_W'(1));
    assign drain_rows = ifs_q - row_in_q;

    assign top_sum  = {1'b0, top_q} + {1'b0, s_q};
    assign top_next = (top_sum >= {1'b0, k_q}) ? CFG_W'(top_sum - {1'b0, k_q}) : top_sum[CFG_W-1:0];

    assign lb_waddr = ADDR_W'(32'(wslot_q) * MAX_INCOL + 32'(wcol_q));
    assign lb_raddr = ADDR_W'(32'(kslot_q) * MAX_INCOL + 32'(base_q) + 32'(w_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sData_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                sData_ready = 1'b1;
                if (sData_valid && in_row_end && rows_left_q == CFG_W'(1)) state_d = S_EMIT;
            end
            S_EMIT: begin
                if (emit_done) begin
                    if (!last_row)                     state_d = S_LOAD;
                    else if (drain_rows == '0)         state_d = S_IDLE;
                    else                               state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                sData_ready = 1'b1;
                if (sData_valid && in_row_end && rows_left_q == CFG_W'(1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0; s_q <= '0; win_q <= '0; ifs_q <= '0; ofs_q <= '0; oc_q <= '0;
            incol_q <= '0; orow_q <= '0; ocg_q <= '0; sl_q <= '0; tgp_q <= '0;
            wslot_q <= '0; wcol_q <= '0; row_in_q <= '0; rows_left_q <= '0;
            top_q <= '0; out_row_q <= '0; w_q <= '0; kr_q <= '0; kslot_q <= '0;
            g_q <= '0; cg_q <= '0; base_q <= '0; gbase_q <= '0; acc_q <= '0;
        end else begin
            if (start_go) begin
                k_q     <= Kernel_Size;
                s_q     <= Stride;
                win_q   <= Window_Size;
                ifs_q   <= InFeature_Size;
                ofs_q   <= OutFeature_Size;
                oc_q    <= OutCol_Count_Times;
                incol_q <= InCol_Count_Times;
                orow_q  <= OutRow_Count_Times;
                ocg_q   <= OutFeature_Channel_Count_Times;
                sl_q    <= Sliding_Size;
                tgp_q   <= Test_Generate_Period;
                wslot_q <= '0; wcol_q <= '0; row_in_q <= '0; rows_left_q <= Kernel_Size;
                top_q <= '0; out_row_q <= '0; w_q <= '0; kr_q <= '0; kslot_q <= '0;
                g_q <= '0; cg_q <= '0; base_q <= '0; gbase_q <= '0;
                acc_q <= {{CFG_W{1'b0}}, OutCol_Count_Times};
            end
            if (accept) begin
                if (in_row_end) begin
                    wcol_q      <= '0;
                    rows_left_q <= rows_left_q - CFG_W'(1);
                    row_in_q    <= row_in_q + CFG_W'(1);
                    wslot_q     <= (wslot_q == k_q - CFG_W'(1)) ? '0 : wslot_q + CFG_W'(1);
                end else begin
                    wcol_q <= wcol_q + CFG_W'(1);
                end
            end
            if (emit_done) begin
                w_q <= '0; kr_q <= '0; g_q <= '0; cg_q <= '0; base_q <= '0; gbase_q <= '0;
                acc_q       <= {{CFG_W{1'b0}}, oc_q};
                kslot_q     <= top_next;
                top_q       <= top_next;
                out_row_q   <= out_row_q + CFG_W'(1);
                rows_left_q <= last_row ? drain_rows : s_q;
            end else if (rd_en) begin
                // acc_q tracks (column-in-group + 1) * OutCol, reaching OutFeature_Size at group end
                if (!w_end) begin
                    w_q <= w_q + CFG_W'(1);
                end else begin
                    w_q <= '0;
                    if (!kr_end) begin
                        kr_q    <= kr_q + CFG_W'(1);
                        kslot_q <= (kslot_q == k_q - CFG_W'(1)) ? '0 : kslot_q + CFG_W'(1);
                    end else begin
                        kr_q    <= '0;
                        kslot_q <= top_q;
                        if (!col_end) begin
                            acc_q  <= acc_q + {{CFG_W{1'b0}}, oc_q};
                            base_q <= base_q + sl_q;
                        end else begin
                            acc_q <= {{CFG_W{1'b0}}, oc_q};
                            if (!g_end) begin
                                g_q    <= g_q + CFG_W'(1);
                                base_q <= gbase_q;
                            end else begin
                                g_q     <= '0;
                                cg_q    <= cg_q + CFG_W'(1);
                                base_q  <= base_q + sl_q;
                                gbase_q <= base_q + sl_q;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) lb_mem[lb_waddr] <= sData_payload;
        if (rd_en) rd_data_q <= lb_mem[lb_raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v_q      <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_rowend_q <= 1'b0;
            rd_sel_q    <= 1'b0;
        end else begin
            rd_v_q      <= rd_en;
            rd_last_q   <= row_end_rd && last_row;
            rd_rowend_q <= row_end_rd;
            rd_sel_q    <= ((out_row_q + CFG_W'(1)) == tgp_q);
        end
    end

    assign push = rd_v_q;
    assign pop  = mValid && mReady;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[fifo_wp_q] <= rd_data_q;
            fifo_tag_q[fifo_wp_q]  <= {rd_last_q, rd_rowend_q, rd_sel_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wp_q  <= '0;
            fifo_rp_q  <= '0;
            fifo_cnt_q <= '0;
            te_q       <= 1'b0;
        end else begin
            te_q <= pop && fifo_tag_q[fifo_rp_q][1] && fifo_tag_q[fifo_rp_q][0];
            if (start_go && Fifo_Clear) begin
                fifo_wp_q  <= '0;
                fifo_rp_q  <= '0;
                fifo_cnt_q <= '0;
            end else begin
                if (push) fifo_wp_q <= fifo_wp_q + 2'd1;
                if (pop)  fifo_rp_q <= fifo_rp_q + 2'd1;
                fifo_cnt_q <= fifo_cnt_q + {2'b0, push} - {2'b0, pop};
            end
        end
    end

    assign mValid      = (fifo_cnt_q != 3'd0);
    assign mData       = mValid ? fifo_data_q[fifo_rp_q] : '0;
    assign mLast       = mValid && fifo_tag_q[fifo_rp_q][2];
    assign Test_Signal = mValid && fifo_tag_q[fifo_rp_q][0];
    assign Test_End    = te_q;

endmodule

// File: tb/tb_img2col_stream.sv
// Self-checking bench for img2col_stream: directed frames from the test plan plus
// randomized geometries, all checked against a loop-level patch model.
module tb_img2col_stream;

    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, start, sData_valid, sData_ready, mValid, mLast, mReady;
    logic          Fifo_Clear, Test_Signal, Test_End;
    logic [DW-1:0] sData_payload, mData;
    logic [CW-1:0] Stride, Kernel_Size, Window_Size, InFeature_Size, InFeature_Channel;
    logic [CW-1:0] OutFeature_Channel, OutFeature_Size, OutCol_Count_Times, InCol_Count_Times;
    logic [CW-1:0] OutRow_Count_Times, OutFeature_Channel_Count_Times, Sliding_Size, Test_Generate_Period;

    always #5 clk = ~clk;

    img2col_stream dut (
        .clk(clk), .rst(rst), .start(start),
        .sData_valid(sData_valid), .sData_ready(sData_ready), .sData_payload(sData_payload),
        .Stride(Stride), .Kernel_Size(Kernel_Size), .Window_Size(Window_Size),
        .InFeature_Size(InFeature_Size), .InFeature_Channel(InFeature_Channel),
        .OutFeature_Channel(OutFeature_Channel), .OutFeature_Size(OutFeature_Size),
        .OutCol_Count_Times(OutCol_Count_Times), .InCol_Count_Times(InCol_Count_Times),
        .OutRow_Count_Times(OutRow_Count_Times),
        .OutFeature_Channel_Count_Times(OutFeature_Channel_Count_Times),
        .Sliding_Size(Sliding_Size),
        .mData(mData), .mValid(mValid), .mLast(mLast), .mReady(mReady),
        .Fifo_Clear(Fifo_Clear), .Test_Signal(Test_Signal), .Test_End(Test_End),
        .Test_Generate_Period(Test_Generate_Period)
    );

    int checks = 0;
    int failures = 0;

    int cfg_k, cfg_s, cfg_ifs, cfg_ch, cfg_ocg, cfg_ofs, cfg_orow, cfg_oc, cfg_tgp;

    logic [DW-1:0] in_words[$];
    logic [DW-1:0] exp_data[$];
    bit            exp_last[$];
    bit            exp_tsig[$];
    logic [DW-1:0] got_data[$];
    bit            got_last[$];
    bit            got_tsig[$];
    int            te_count, te_at, stall_err;
    bit            timed_out;

    task automatic set_basic(input int ocg, input int tgp);
        cfg_k = 2; cfg_s = 2; cfg_ifs = 4; cfg_ch = 8; cfg_ocg = ocg;
        cfg_ofs = 2; cfg_orow = 2; cfg_oc = 1; cfg_tgp = tgp;
    endtask

    task automatic apply_cfg();
        Kernel_Size                    = CW'(cfg_k);
        Stride                         = CW'(cfg_s);
        InFeature_Size                 = CW'(cfg_ifs);
        InFeature_Channel              = CW'(cfg_ch);
        InCol_Count_Times              = CW'(cfg_ifs * cfg_ch / 8);
        Window_Size                    = CW'(cfg_k * cfg_ch / 8);
        Sliding_Size                   = CW'(cfg_s * cfg_ch / 8);
        OutFeature_Channel             = CW'(cfg_ocg * 8);
        OutFeature_Channel_Count_Times = CW'(cfg_ocg);
        OutFeature_Size                = CW'(cfg_ofs);
        OutRow_Count_Times             = CW'(cfg_orow);
        OutCol_Count_Times             = CW'(cfg_oc);
        Test_Generate_Period           = CW'(cfg_tgp);
    endtask

    function automatic void fill_inputs(input bit rnd);
        int n;
        n = cfg_ifs * (cfg_ifs * cfg_ch / 8);
        in_words.delete();
        for (int i = 0; i < n; i++)
            in_words.push_back(rnd ? {$urandom, $urandom} : DW'(i));
    endfunction

    // Patch model: for each output pixel, gather K kernel rows of Window words from the image.
    function automatic void build_expected();
        int incol, win, sl, gs, c, row, col;
        incol = cfg_ifs * cfg_ch / 8;
        win   = cfg_k * cfg_ch / 8;
        sl    = cfg_s * cfg_ch / 8;
        gs    = cfg_ofs / cfg_oc;
        exp_data.delete(); exp_last.delete(); exp_tsig.delete();
        for (int r = 0; r < cfg_orow; r++)
            for (int cg = 0; cg < cfg_oc; cg++)
                for (int g = 0; g < cfg_ocg; g++)
                    for (int ci = 0; ci < gs; ci++)
                        for (int kr = 0; kr < cfg_k; kr++)
                            for (int w = 0; w < win; w++) begin
                                c   = cg * gs + ci;
                                row = r * cfg_s + kr;
                                col = c * sl + w;
                                exp_data.push_back(in_words[row * incol + col]);
                                exp_last.push_back(r == cfg_orow - 1 && cg == cfg_oc - 1 && g == cfg_ocg - 1 &&
                                                   ci == gs - 1 && kr == cfg_k - 1 && w == win - 1);
                                exp_tsig.push_back(r + 1 == cfg_tgp);
                            end
    endfunction

    // rdy_mode: 0 always ready, 1 ready one cycle in three, 2 random
    task automatic run_frame(input int stop_after, input int rdy_mode, input bit rnd_valid, input bit fclr);
        int            idx, cyc, post, total;
        bit            stalled;
        logic [DW-1:0] held;
        got_data.delete(); got_last.delete(); got_tsig.delete();
        te_count = 0; te_at = -1; stall_err = 0; timed_out = 0;
        idx = 0; cyc = 0; post = 0; stalled = 0; held = '0;
        total = in_words.size();
        apply_cfg();
        @(negedge clk);
        start = 1'b1; Fifo_Clear = fclr;
        @(negedge clk);
        start = 1'b0; Fifo_Clear = 1'b0;
        forever begin
            if (idx < total) begin
                sData_valid   = rnd_valid ? ($urandom_range(0, 1) == 1) : 1'b1;
                sData_payload = in_words[idx];
            end else begin
                sData_valid = 1'b0;
            end
            if (sData_valid && sData_ready) idx++;
            mReady = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 0) : ($urandom_range(0, 2) != 0);
            if (stalled && (!mValid || mData !== held)) stall_err++;
            if (Test_End) begin
                te_count++;
                te_at = got_data.size();
            end
            if (mValid && mReady) begin
                got_data.push_back(mData);
                got_last.push_back(mLast);
                got_tsig.push_back(Test_Signal);
                stalled = 1'b0;
            end else begin
                stalled = mValid;
                held    = mData;
            end
            cyc++;
            if (stop_after > 0 && got_data.size() >= stop_after) break;
            if (got_data.size() >= exp_data.size() && idx >= total) begin
                post++;
                if (post > 12) break;
            end
            if (cyc > 20000) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
        end
        sData_valid = 1'b0;
        mReady      = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (mValid !== 1'b0)      begin failures++; $display("FAIL reset_mValid got=%b exp=0", mValid); end
        checks++; if (mData !== '0)         begin failures++; $display("FAIL reset_mData got=%h exp=0", mData); end
        checks++; if (mLast !== 1'b0)       begin failures++; $display("FAIL reset_mLast got=%b exp=0", mLast); end
        checks++; if (sData_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", sData_ready); end
        checks++; if (Test_Signal !== 1'b0) begin failures++; $display("FAIL reset_tsig got=%b exp=0", Test_Signal); end
        checks++; if (Test_End !== 1'b0)    begin failures++; $display("FAIL reset_tend got=%b exp=0", Test_End); end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: outputs checked");
    endtask

    task automatic test_basic_frame();
        int seq [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
        set_basic(1, 0);
        fill_inputs(0);
        exp_data.delete(); exp_last.delete();
        for (int i = 0; i < 16; i++) begin
            exp_data.push_back(DW'(seq[i]));
            exp_last.push_back(i == 15);
        end
        run_frame(0, 0, 0, 1);
        checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout got=%0d exp=%0d words", got_data.size(), 16); end
        checks++; if (got_data.size() != 16) begin failures++; $display("FAIL basic_count got=%0d exp=16", got_data.size()); end
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL basic_word[%0d] got=%0d/last%0b exp=%0d/last%0b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        $display("basic frame: %0d words", got_data.size());
    endtask

    task automatic test_overlap();
        int seq [16] = '{0, 1, 3, 4, 1, 2, 4, 5, 3, 4, 6, 7, 4, 5, 7, 8};
        cfg_k = 2; cfg_s = 1; cfg_ifs = 3; cfg_ch = 8; cfg_ocg = 1;
        cfg_ofs = 2; cfg_orow = 2; cfg_oc = 1; cfg_tgp = 0;
        fill_inputs(0);
        build_expected();
        run_frame(0, 0, 0, 1);
        checks++; if (timed_out) begin failures++; $display("FAIL overlap_timeout got=%0d exp=16 words", got_data.size()); end
        checks++; if (got_data.size() != 16) begin failures++; $display("FAIL overlap_count got=%0d exp=16", got_data.size()); end
        for (int i = 0; i < 16 && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== DW'(seq[i]) || got_last[i] !== (i == 15)) begin
                failures++;
                $display("FAIL overlap_word[%0d] got=%0d/last%0b exp=%0d/last%0b", i, got_data[i], got_last[i], seq[i], i == 15);
            end
        end
        $display("overlapped windows: %0d words", got_data.size());
    endtask

    task automatic test_channel_groups();
        set_basic(2, 0);
        fill_inputs(0);
        build_expected();
        run_frame(0, 0, 0, 1);
        checks++; if (timed_out) begin failures++; $display("FAIL chgrp_timeout got=%0d exp=32 words", got_data.size()); end
        checks++; if (got_data.size() != 32) begin failures++; $display("FAIL chgrp_count got=%0d exp=32", got_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL chgrp_word[%0d] got=%0d/last%0b exp=%0d/last%0b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        $display("channel-group repeat: %0d words", got_data.size());
    endtask

    task automatic test_backpressure();
        set_basic(1, 0);
        fill_inputs(0);
        build_expected();
        run_frame(0, 1, 1, 1);
        checks++; if (timed_out) begin failures++; $display("FAIL bp_timeout got=%0d exp=%0d words", got_data.size(), exp_data.size()); end
        checks++; if (got_data.size() != exp_data.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_data.size(), exp_data.size()); end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stable got=%0d changes exp=0", stall_err); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL bp_word[%0d] got=%0d/last%0b exp=%0d/last%0b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        $display("backpressure: %0d words, %0d stall changes", got_data.size(), stall_err);
    endtask

    task automatic test_debug_capture();
        set_basic(1, 2);
        fill_inputs(0);
        build_expected();
        run_frame(0, 0, 0, 1);
        checks++; if (got_data.size() != 16) begin failures++; $display("FAIL dbg_count got=%0d exp=16", got_data.size()); end
        for (int i = 0; i < 16 && i < got_tsig.size(); i++) begin
            checks++;
            if (got_tsig[i] !== exp_tsig[i]) begin
                failures++;
                $display("FAIL dbg_tsig[%0d] got=%0b exp=%0b", i, got_tsig[i], exp_tsig[i]);
            end
        end
        checks++; if (te_count != 1) begin failures++; $display("FAIL dbg_tend_count got=%0d exp=1", te_count); end
        checks++; if (te_at != 16)   begin failures++; $display("FAIL dbg_tend_pos got=%0d exp=16", te_at); end
        $display("debug capture: Test_End pulses=%0d after word count %0d", te_count, te_at);
    endtask

    task automatic test_mid_frame_reset();
        set_basic(1, 1);
        fill_inputs(0);
        build_expected();
        run_frame(3, 0, 0, 1);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (mValid !== 1'b0)      begin failures++; $display("FAIL midrst_mValid got=%b exp=0", mValid); end
        checks++; if (mData !== '0)         begin failures++; $display("FAIL midrst_mData got=%h exp=0", mData); end
        checks++; if (mLast !== 1'b0 || Test_Signal !== 1'b0 || Test_End !== 1'b0 || sData_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ctrl got=%b%b%b%b exp=0000", mLast, Test_Signal, Test_End, sData_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        run_frame(0, 0, 0, 0);
        checks++; if (got_data.size() != exp_data.size()) begin failures++; $display("FAIL midrst_count got=%0d exp=%0d", got_data.size(), exp_data.size()); end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                failures++;
                $display("FAIL midrst_word[%0d] got=%0d/last%0b exp=%0d/last%0b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        $display("mid-frame reset: restart produced %0d words", got_data.size());
    endtask

    task automatic test_random_configs();
        int need, d;
        for (int it = 0; it < 4; it++) begin
            cfg_k    = $urandom_range(1, 4);
            cfg_s    = $urandom_range(1, cfg_k);
            cfg_ch   = 8 * $urandom_range(1, 2);
            cfg_ocg  = $urandom_range(1, 2);
            cfg_ofs  = $urandom_range(1, 4);
            d = $urandom_range(1, cfg_ofs);
            while (cfg_ofs % d != 0) d = $urandom_range(1, cfg_ofs);
            cfg_oc   = d;
            cfg_orow = $urandom_range(1, 3);
            need = (cfg_orow - 1) * cfg_s + cfg_k;
            if ((cfg_ofs - 1) * cfg_s + cfg_k > need) need = (cfg_ofs - 1) * cfg_s + cfg_k;
            cfg_ifs  = need + $urandom_range(0, 2);
            cfg_tgp  = $urandom_range(0, cfg_orow);
            fill_inputs(1);
            build_expected();
            run_frame(0, 2, 1, 1);
            checks++; if (timed_out) begin failures++; $display("FAIL rnd%0d_timeout got=%0d exp=%0d words", it, got_data.size(), exp_data.size()); end
            checks++; if (got_data.size() != exp_data.size()) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, got_data.size(), exp_data.size()); end
            checks++; if (stall_err != 0) begin failures++; $display("FAIL rnd%0d_stable got=%0d exp=0", it, stall_err); end
            for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
                checks++;
                if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_tsig[i] !== exp_tsig[i]) begin
                    failures++;
                    $display("FAIL rnd%0d_word[%0d] got=%h/%0b/%0b exp=%h/%0b/%0b", it, i,
                             got_data[i], got_last[i], got_tsig[i], exp_data[i], exp_last[i], exp_tsig[i]);
                end
            end
            $display("random cfg %0d: K=%0d S=%0d ch=%0d ifs=%0d ofs=%0d oc=%0d orow=%0d ocg=%0d words=%0d",
                     it, cfg_k, cfg_s, cfg_ch, cfg_ifs, cfg_ofs, cfg_oc, cfg_orow, cfg_ocg, got_data.size());
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sData_valid = 1'b0; sData_payload = '0;
        mReady = 1'b1; Fifo_Clear = 1'b0;
        set_basic(1, 0);
        apply_cfg();
        test_reset();
        test_basic_frame();
        test_overlap();
        test_channel_groups();
        test_backpressure();
        test_debug_capture();
        test_mid_frame_reset();
        test_random_configs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
